pulse_param_loader: RTL and testbench

Serial front end for the pulse sequencer. It receives 8N1 UART frames on `rxd`, decodes register-write and commit commands, and holds every timing parameter in a shadow bank. On a commit command it copies the whole shadow bank atomically into the active outputs. Those outputs drive the sequencer's `pu`, `per`, `p1wid`, `del`, `p2wid`, `nut_w`, `nut_d`, `cp`, `p_bl`, `p_bl_off` and `bl` inputs directly.

---
 rtl/pulse_pkg.sv | 90 +++++++++
 rtl/uart_rx.sv | 110 +++++++++++
 rtl/pulse_param_loader.sv | 191 +++++++++++++++++++
 tb/tb_pulse_param_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared constants, reset defaults, state enums and register-bank helpers for pulse_param_loader.
// PULSE_LOADER_CHECKSUM_EN adds the trailing CSUM byte and its frame state.
package pulse_pkg;

  localparam logic [7:0] HEADER      = 8'hA5;
  localparam logic [7:0] ADDR_PU     = 8'h00;
  localparam logic [7:0] ADDR_PER    = 8'h01;
  localparam logic [7:0] ADDR_P1WID  = 8'h02;
  localparam logic [7:0] ADDR_DEL    = 8'h03;
  localparam logic [7:0] ADDR_P2WID  = 8'h04;
  localparam logic [7:0] ADDR_NUT_W  = 8'h05;
  localparam logic [7:0] ADDR_NUT_D  = 8'h06;
  localparam logic [7:0] ADDR_CP     = 8'h07;
  localparam logic [7:0] ADDR_P_BL   = 8'h08;
  localparam logic [7:0] ADDR_BL_OFF = 8'h09;
  localparam logic [7:0] ADDR_BL     = 8'h0A;
  localparam logic [7:0] ADDR_COMMIT = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
`ifdef PULSE_LOADER_CHECKSUM_EN
    ST_CSUM  = 3'd3,
`endif
    ST_APPLY = 3'd4
  } frame_state_e;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic        pu;
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [31:0] nut_w;
    logic [31:0] nut_d;
    logic [7:0]  cp;
    logic [7:0]  p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } params_t;

  // Must track the sequencer's own power-up defaults.
  localparam params_t PARAMS_RST = '{
    pu:       1'b1,
    per:      8'd1,
    p1wid:    16'd30,
    del:      16'd200,
    p2wid:    16'd30,
    nut_w:    32'd50,
    nut_d:    32'd300,
    cp:       8'd3,
    p_bl:     8'd50,
    p_bl_off: 16'd100,
    bl:       1'b1
  };

  function automatic logic addr_is_reg(input logic [7:0] addr);
    return (addr <= ADDR_BL);
  endfunction

  function automatic params_t write_field(input params_t cur, input logic [7:0] addr,
                                          input logic [31:0] data);
    params_t nxt;
    nxt = cur;
    case (addr)
      ADDR_PU:     nxt.pu       = data[0];
      ADDR_PER:    nxt.per      = data[7:0];
      ADDR_P1WID:  nxt.p1wid    = data[15:0];
      ADDR_DEL:    nxt.del      = data[15:0];
      ADDR_P2WID:  nxt.p2wid    = data[15:0];
      ADDR_NUT_W:  nxt.nut_w    = data;
      ADDR_NUT_D:  nxt.nut_d    = data;
      ADDR_CP:     nxt.cp       = data[7:0];
      ADDR_P_BL:   nxt.p_bl     = data[7:0];
      ADDR_BL_OFF: nxt.p_bl_off = data[15:0];
      ADDR_BL:     nxt.bl       = data[0];
      default:     nxt          = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, stop-bit framing check.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1746
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr
);
  import pulse_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  rx_state_e        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  logic rxd_s, fall_s, half_hit_s, bit_hit_s;

  assign rxd_s      = sync_q[1];
  assign fall_s     = prev_q & ~rxd_s;
  assign half_hit_s = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));
  assign bit_hit_s  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // State and datapath registers; line idles high out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX_IDLE;
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic; a high line at mid start bit is treated as a glitch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall_s) state_d = RX_START; else state_d = RX_IDLE;
      RX_START: if (half_hit_s) state_d = rxd_s ? RX_IDLE : RX_DATA; else state_d = RX_START;
      RX_DATA:  if (bit_hit_s && (bit_q == 3'd7)) state_d = RX_STOP; else state_d = RX_DATA;
      RX_STOP:  if (bit_hit_s) state_d = RX_IDLE; else state_d = RX_STOP;
      default:  state_d = RX_IDLE;
    endcase
  end

  // Bit timing, LSB-first shifting and framing check.
  always_comb begin
    sync_d  = {sync_q[0], rxd};
    prev_d  = rxd_s;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        bit_d = 3'd0;
      end
      RX_START: begin
        if (half_hit_s) cnt_d = '0; else cnt_d = cnt_q + CNT_W'(1);
      end
      RX_DATA: begin
        if (bit_hit_s) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (bit_hit_s) begin
          cnt_d   = '0;
          valid_d = rxd_s;
          ferr_d  = ~rxd_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rx_byte  = shift_q;
  assign rx_valid = valid_q;
  assign rx_ferr  = ferr_q;

endmodule

// File: rtl/pulse_param_loader.sv
// UART-fed shadow/active parameter bank for the pulse sequencer; commit copies shadow to active.
// Define PULSE_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module pulse_param_loader #(
  parameter int unsigned CLKS_PER_BIT = 1746,
  parameter int unsigned GAP_TIMEOUT  = 1048576
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic        rxd,
  output logic        pu,
  output logic [7:0]  per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [31:0] nut_w,
  output logic [31:0] nut_d,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        cmd_done,
  output logic        err
);
  import pulse_pkg::*;

  localparam int GAP_W = $clog2(GAP_TIMEOUT);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr;

  frame_state_e     state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       idx_q, idx_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  params_t          shadow_q, shadow_d;
  params_t          active_q, active_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
`ifdef PULSE_LOADER_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  logic gap_expired_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk_pll),
    .rst      (reset),
    .rxd      (rxd),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign gap_expired_s = (state_q != ST_IDLE) && (state_q != ST_APPLY) && !rx_valid &&
                         (gap_q == GAP_W'(GAP_TIMEOUT - 1));

  // Frame state, assembly registers and both register banks.
  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 8'h00;
      data_q   <= 32'h0000_0000;
      idx_q    <= 2'd0;
      gap_q    <= '0;
      shadow_q <= PARAMS_RST;
      active_q <= PARAMS_RST;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef PULSE_LOADER_CHECKSUM_EN
      csum_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      gap_q    <= gap_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef PULSE_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Frame sequencing; a framing error or gap timeout always abandons the frame.
  always_comb begin
    state_d = state_q;
    if (rx_ferr || gap_expired_s) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (rx_valid && (rx_byte == HEADER)) state_d = ST_ADDR; else state_d = ST_IDLE;
        ST_ADDR:  if (rx_valid) state_d = ST_DATA; else state_d = ST_ADDR;
        ST_DATA: begin
          if (rx_valid && (idx_q == 2'd3)) begin
`ifdef PULSE_LOADER_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_APPLY;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end
`ifdef PULSE_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (rx_valid) state_d = (rx_byte == csum_q) ? ST_APPLY : ST_IDLE;
          else state_d = ST_CSUM;
        end
`endif
        ST_APPLY: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Byte capture, APPLY writes/commit and the done/err strobes.
  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    active_d = active_q;
    done_d   = 1'b0;
    err_d    = rx_ferr | gap_expired_s;
    gap_d    = ((state_q == ST_IDLE) || rx_valid) ? '0 : gap_q + GAP_W'(1);
`ifdef PULSE_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      ST_IDLE: idx_d = 2'd0;
      ST_ADDR: begin
        if (rx_valid) begin
          addr_d = rx_byte;
          idx_d  = 2'd0;
`ifdef PULSE_LOADER_CHECKSUM_EN
          csum_d = rx_byte;
`endif
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DATA: begin
        if (rx_valid) begin
          data_d[{idx_q, 3'b000} +: 8] = rx_byte;
          idx_d = idx_q + 2'd1;
`ifdef PULSE_LOADER_CHECKSUM_EN
          csum_d = csum_q ^ rx_byte;
`endif
        end else begin
          idx_d = idx_q;
        end
      end
`ifdef PULSE_LOADER_CHECKSUM_EN
      ST_CSUM: err_d = rx_ferr | gap_expired_s | (rx_valid && (rx_byte != csum_q));
`endif
      ST_APPLY: begin
        if (addr_q == ADDR_COMMIT) begin
          active_d = shadow_q;
          done_d   = ~err_d;
        end else if (addr_is_reg(addr_q)) begin
          shadow_d = write_field(shadow_q, addr_q, data_q);
          done_d   = ~err_d;
        end else begin
          err_d = 1'b1;
        end
      end
      default: idx_d = 2'd0;
    endcase
  end

  assign pu       = active_q.pu;
  assign per      = active_q.per;
  assign p1wid    = active_q.p1wid;
  assign del      = active_q.del;
  assign p2wid    = active_q.p2wid;
  assign nut_w    = active_q.nut_w;
  assign nut_d    = active_q.nut_d;
  assign cp       = active_q.cp;
  assign p_bl     = active_q.p_bl;
  assign p_bl_off = active_q.p_bl_off;
  assign bl       = active_q.bl;
  assign cmd_done = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pulse_param_loader.sv
// Scoreboard bench for pulse_param_loader: directed UART frames, expected events queued, monitor compares.
module tb_pulse_param_loader;

  localparam int CPB = 16;
  localparam int GAP = 400;

  logic        clk_pll = 1'b0;
  logic        reset;
  logic        rxd;
  logic        pu, bl, cmd_done, err;
  logic [7:0]  per, cp, p_bl;
  logic [15:0] p1wid, del, p2wid, p_bl_off;
  logic [31:0] nut_w, nut_d;

  always #5 clk_pll = ~clk_pll;

  pulse_param_loader #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(GAP)) dut (
    .clk_pll(clk_pll), .reset(reset), .rxd(rxd),
    .pu(pu), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .nut_w(nut_w), .nut_d(nut_d), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off), .bl(bl),
    .cmd_done(cmd_done), .err(err)
  );

  typedef struct packed {
    logic        pu;
    logic [7:0]  per;
    logic [15:0] p1wid, del, p2wid;
    logic [31:0] nut_w, nut_d;
    logic [7:0]  cp, p_bl;
    logic [15:0] p_bl_off;
    logic        bl;
  } outs_t;

  typedef struct packed {
    logic  is_err;
    outs_t o;
  } ev_t;

  ev_t   sb_q[$];
  outs_t exp_sh, exp_act;
  int    n_checks = 0;
  int    n_fail   = 0;

  function automatic outs_t rst_outs();
    outs_t r;
    r.pu = 1'b1; r.per = 8'd1; r.p1wid = 16'd30; r.del = 16'd200; r.p2wid = 16'd30;
    r.nut_w = 32'd50; r.nut_d = 32'd300; r.cp = 8'd3; r.p_bl = 8'd50;
    r.p_bl_off = 16'd100; r.bl = 1'b1;
    return r;
  endfunction

  function automatic outs_t dut_outs();
    outs_t r;
    r.pu = pu; r.per = per; r.p1wid = p1wid; r.del = del; r.p2wid = p2wid;
    r.nut_w = nut_w; r.nut_d = nut_d; r.cp = cp; r.p_bl = p_bl;
    r.p_bl_off = p_bl_off; r.bl = bl;
    return r;
  endfunction

  function automatic outs_t model_write(input outs_t s, input logic [7:0] a, input logic [31:0] d);
    outs_t r;
    r = s;
    case (a)
      8'h00: r.pu = d[0];
      8'h01: r.per = d[7:0];
      8'h02: r.p1wid = d[15:0];
      8'h03: r.del = d[15:0];
      8'h04: r.p2wid = d[15:0];
      8'h05: r.nut_w = d;
      8'h06: r.nut_d = d;
      8'h07: r.cp = d[7:0];
      8'h08: r.p_bl = d[7:0];
      8'h09: r.p_bl_off = d[15:0];
      8'h0A: r.bl = d[0];
      default: r = s;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input outs_t a, input outs_t e);
    chk({tag, ".pu"}, 32'(a.pu), 32'(e.pu));
    chk({tag, ".per"}, 32'(a.per), 32'(e.per));
    chk({tag, ".p1wid"}, 32'(a.p1wid), 32'(e.p1wid));
    chk({tag, ".del"}, 32'(a.del), 32'(e.del));
    chk({tag, ".p2wid"}, 32'(a.p2wid), 32'(e.p2wid));
    chk({tag, ".nut_w"}, a.nut_w, e.nut_w);
    chk({tag, ".nut_d"}, a.nut_d, e.nut_d);
    chk({tag, ".cp"}, 32'(a.cp), 32'(e.cp));
    chk({tag, ".p_bl"}, 32'(a.p_bl), 32'(e.p_bl));
    chk({tag, ".p_bl_off"}, 32'(a.p_bl_off), 32'(e.p_bl_off));
    chk({tag, ".bl"}, 32'(a.bl), 32'(e.bl));
  endtask

  // Monitor: pops one expected event per cmd_done/err pulse, otherwise outputs must hold.
  initial begin : monitor
    outs_t cur;
    ev_t   ev;
    cur = rst_outs();
    forever begin
      @(negedge clk_pll);
      if (reset) begin
        cur = rst_outs();
      end else begin
        if (cmd_done || err) begin
          chk("done_err_exclusive", 32'(cmd_done & err), 32'd0);
          if (sb_q.size() == 0) begin
            chk("unexpected_event(err)", 32'(err), 32'(1'b0));
            chk("unexpected_event(cmd_done)", 32'(cmd_done), 32'(1'b0));
          end else begin
            ev = sb_q.pop_front();
            chk("event_kind_err", 32'(err), 32'(ev.is_err));
            if (!ev.is_err) begin
              cur = ev.o;
              chk_outs("commit_snapshot", dut_outs(), cur);
            end
          end
        end
        n_checks++;
        if (dut_outs() !== cur) begin
          n_fail++;
          $display("FAIL outputs_hold: got %h expected %h", dut_outs(), cur);
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    #1 rxd = v;
    repeat (CPB) @(posedge clk_pll);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_ok ? 1'b1 : 1'b0);
    drive_bit(1'b1);
  endtask

  // Sends one frame; the expected outcome is queued just before the byte that triggers it.
  task automatic send_frame(input logic [7:0] addr, input logic [31:0] data,
                            input int ferr_idx, input bit bad_csum);
    logic [7:0] bytes [0:6];
    int         nb;
    ev_t        ev;
    bytes[0] = 8'hA5; bytes[1] = addr;
    bytes[2] = data[7:0]; bytes[3] = data[15:8]; bytes[4] = data[23:16]; bytes[5] = data[31:24];
    bytes[6] = addr ^ data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24] ^ (bad_csum ? 8'h01 : 8'h00);
`ifdef PULSE_LOADER_CHECKSUM_EN
    nb = 7;
`else
    nb = 6;
`endif
    for (int i = 0; i < nb; i++) begin
      if (i == ferr_idx) begin
        ev.is_err = 1'b1; ev.o = exp_act;
        sb_q.push_back(ev);
        send_byte(bytes[i], 1'b0);
        return;
      end
      if (i == nb - 1) begin
        ev.o = exp_act;
        if (bad_csum && (nb == 7)) begin
          ev.is_err = 1'b1;
        end else if (addr == 8'h0F) begin
          exp_act = exp_sh;
          ev.is_err = 1'b0; ev.o = exp_act;
        end else if (addr <= 8'h0A) begin
          exp_sh = model_write(exp_sh, addr, data);
          ev.is_err = 1'b0;
        end else begin
          ev.is_err = 1'b1;
        end
        sb_q.push_back(ev);
      end
      send_byte(bytes[i], 1'b1);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk_pll);
    end
    chk({name, ".pending_events"}, 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin : watchdog
    repeat (90000) @(posedge clk_pll);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    ev_t ev;
    rxd = 1'b1;
    reset = 1'b1;
    exp_sh = rst_outs();
    exp_act = rst_outs();
    repeat (4) @(posedge clk_pll);
    #1;
    chk_outs("reset", dut_outs(), rst_outs());
    chk("reset.cmd_done", 32'(cmd_done), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    reset = 1'b0;
    repeat (20) @(posedge clk_pll);

    // Stray non-header byte in IDLE is ignored.
    send_byte(8'h5A, 1'b1);
    wait_drain("stray", 64);

    send_frame(8'h03, 32'h0000_01F4, -1, 1'b0);
    wait_drain("del_write", 64);
    chk("del_before_commit", 32'(del), 32'd200);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("commit1", 64);
    chk("del_after_commit", 32'(del), 32'd500);

    // Bad stop bit on D1 aborts the cp write.
    send_frame(8'h07, 32'h0000_0005, 3, 1'b0);
    wait_drain("ferr_d1", 64);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("commit2", 64);
    chk("cp_after_ferr", 32'(cp), 32'd3);

    send_frame(8'h0C, 32'h0000_0001, -1, 1'b0);
    wait_drain("bad_addr", 64);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("commit3", 64);

    // Partial frame then silence: gap timeout.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    ev.is_err = 1'b1; ev.o = exp_act;
    sb_q.push_back(ev);
    wait_drain("gap_timeout", GAP + 200);
    send_frame(8'h02, 32'h0000_0040, -1, 1'b0);
    wait_drain("p1wid_write", 64);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("commit4", 64);
    chk("p1wid_after_gap", 32'(p1wid), 32'd64);

    // Header value inside payload is data; truncation to field width; bl boundary address.
    send_frame(8'h05, 32'h0000_00A5, -1, 1'b0);
    send_frame(8'h0A, 32'h0000_0000, -1, 1'b0);
    send_frame(8'h01, 32'h1234_5678, -1, 1'b0);
    wait_drain("multi_write", 64);
    send_frame(8'h0F, 32'hFFFF_FFFF, -1, 1'b0);
    wait_drain("commit5", 64);
    chk("nut_w_a5", nut_w, 32'h0000_00A5);
    chk("per_trunc", 32'(per), 32'h78);
    chk("bl_cleared", 32'(bl), 32'd0);

`ifdef PULSE_LOADER_CHECKSUM_EN
    send_frame(8'h01, 32'h0000_000A, -1, 1'b1);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("csum_bad", 64);
    chk("per_after_bad_csum", 32'(per), 32'h78);
    send_frame(8'h01, 32'h0000_000A, -1, 1'b0);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("csum_good", 64);
    chk("per_after_good_csum", 32'(per), 32'd10);
`endif

    // Async reset mid-frame: outputs return at once and no partial write survives.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h40, 1'b1);
    @(posedge clk_pll);
    #3 reset = 1'b1;
    #1;
    chk_outs("async_reset", dut_outs(), rst_outs());
    chk("async_reset.cmd_done", 32'(cmd_done), 32'd0);
    exp_sh = rst_outs();
    exp_act = rst_outs();
    sb_q.delete();
    repeat (3) @(posedge clk_pll);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_pll);
    send_frame(8'h0F, 32'h0000_0000, -1, 1'b0);
    wait_drain("commit_after_reset", 64);
    chk_outs("post_reset_commit", dut_outs(), rst_outs());

    repeat (20) @(posedge clk_pll);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
